// File: rtl/rfft_pkg.sv
// Shared definitions for the RFFT stimulus path: default widths, the LFSR
// feedback polynomial and the sequencer FSM state encoding.
package rfft_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int CNT_W_DEFAULT  = 9;

    // x^16 + x^14 + x^13 + x^11 + 1 for a right-shifting Galois LFSR
    localparam logic [15:0] LFSR_POLY_DEFAULT = 16'hB400;

    // Sequencer states, 2-bit legacy-compatible encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Output stream of the LFSR sequencer.
// Handshake: a beat transfers on every rising clock edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low the
// master holds out_data, sample_idx and out_last stable.
interface lfsr_seq_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 9
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [CNT_W-1:0]  sample_idx;

    modport master (
        output out_valid, out_data, out_last, sample_idx,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_last, sample_idx,
        output out_ready
    );
endinterface

// File: rtl/lfsr_galois.sv
// 16-bit (parameterisable) right-shifting Galois LFSR register.
// Holds its value unless loaded or stepped; load takes priority over step.
module lfsr_galois #(
    parameter int                DATA_W = 16,
    parameter logic [DATA_W-1:0] POLY   = 16'hB400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              step,
    output logic [DATA_W-1:0] state
);

    logic [DATA_W-1:0] state_q;
    logic [DATA_W-1:0] state_d;

    // Next LFSR value: load, Galois step, or hold
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (step) begin
            state_d = state_q >> 1;
            if (state_q[0]) begin
                state_d = state_d ^ POLY;
            end
        end
    end

    // State register with synchronous reset to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// LFSR stimulus sequencer: captures seed and sample count on start, loads the
// LFSR and streams num_samples words, stepping the LFSR only on accepted beats.
// Optional feature macro: LFSR_ZERO_SEED_GUARD_EN (replace a zero seed by 1 and
// flag it on seed_fixed).
module lfsr_seq_ctrl
    import rfft_pkg::*;
#(
    parameter int                DATA_W = DATA_W_DEFAULT,
    parameter int                CNT_W  = CNT_W_DEFAULT,
    parameter logic [DATA_W-1:0] POLY   = LFSR_POLY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_W-1:0]     seed,
    input  logic [CNT_W-1:0]      num_samples,
    lfsr_seq_ctrl_if.master       out_if,
    output logic                  busy,
    output logic                  done,
    output logic                  seed_fixed,
    output logic [1:0]            dbg_state
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] lfsr_state;
    logic [DATA_W-1:0] load_val;
    logic              lfsr_load;
    logic              lfsr_step;
    logic              fire;
    logic              is_last;
    logic              start_acc;

    assign fire      = (state_q == ST_RUN) && out_if.out_ready;
    assign is_last   = (idx_q == num_q - CNT_W'(1));
    assign start_acc = (state_q == ST_IDLE) && start && !abort;
    // abort freezes the LFSR, so neither load nor step may happen alongside it
    assign lfsr_load = (state_q == ST_LOAD) && !abort;
    assign lfsr_step = fire && !abort;

    // FSM sequencing, parameter capture and beat counting; abort overrides all
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        num_d   = num_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    seed_d  = seed;
                    num_d   = num_samples;
                end
            end
            ST_LOAD: begin
                idx_d   = '0;
                state_d = (num_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (fire) begin
                    idx_d = idx_q + CNT_W'(1);
                    if (is_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            seed_d  = seed_q;
            num_d   = num_q;
            idx_d   = idx_q;
        end
    end

    // Sequencer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            seed_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
        end
    end

`ifdef LFSR_ZERO_SEED_GUARD_EN
    logic seed_fixed_q, seed_fixed_d;

    // Zero is the LFSR lock-up state; substitute 1 so the run still toggles
    assign load_val = (seed_q == '0) ? DATA_W'(1) : seed_q;

    // Flag is decided at start acceptance so it is already high during LOAD
    always_comb begin
        seed_fixed_d = seed_fixed_q;
        if (start_acc) begin
            seed_fixed_d = (seed == '0);
        end
    end

    // Zero-seed flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            seed_fixed_q <= 1'b0;
        end else begin
            seed_fixed_q <= seed_fixed_d;
        end
    end

    assign seed_fixed = seed_fixed_q;
`else
    logic unused_start_acc;

    assign load_val         = seed_q;
    assign seed_fixed       = 1'b0;
    assign unused_start_acc = start_acc;
`endif

    lfsr_galois #(
        .DATA_W (DATA_W),
        .POLY   (POLY)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (load_val),
        .step     (lfsr_step),
        .state    (lfsr_state)
    );

    assign out_if.out_valid  = (state_q == ST_RUN);
    assign out_if.out_data   = lfsr_state;
    assign out_if.sample_idx = idx_q;
    assign out_if.out_last   = (state_q == ST_RUN) && is_last;
    assign busy              = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign done              = (state_q == ST_DONE);
    assign dbg_state         = state_q;

endmodule
